// File: rtl/score_keeper.sv
// Score / high-score keeper: frame-tick driven BCD score, milestone pulse and 4-digit glyph rendering.
// Optional feature macro: SCORE_HISCORE_EN (high-score register, compare and second rendered field).
module score_keeper #(
  parameter int FRAMES_PER_POINT = 6,
  parameter int SCORE_ROW        = 20,
  parameter int SCORE_COL        = 560,
  parameter int HI_GAP           = 60
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        fresh,
  input  logic        game_status,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  output logic [15:0] score,
  output logic [15:0] hiscore,
  output logic        milestone,
  output logic        px
);

  localparam int FC_W = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_POINT - 1);

  // The high-score field sits to the left of the score field and must not overlap it.
  if (FRAMES_PER_POINT < 1 || HI_GAP < 40) begin : g_param_check
    $error("score_keeper: FRAMES_PER_POINT must be >= 1 and HI_GAP >= 40");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_OVER
  } state_t;

  state_t            state_q, state_d;
  logic              fresh_q;
  logic              tick;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]       score_q, score_d;
  logic [15:0]       score_inc;
  logic              milestone_q, milestone_d;
  logic [15:0]       hiscore_q;
  int                col_i, row_i;
  logic              px_lit;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Glyphs packed top row first; bit 3 of each nibble is the leftmost font column.
  function automatic logic [3:0] font_row(input logic [3:0] d, input logic [2:0] fy);
    logic [19:0] g;
    int          fi;
    case (d)
      4'd0:    g = 20'hF999F;
      4'd1:    g = 20'h11111;
      4'd2:    g = 20'hF1F8F;
      4'd3:    g = 20'hF1F1F;
      4'd4:    g = 20'h99F11;
      4'd5:    g = 20'hF8F1F;
      4'd6:    g = 20'hF8F9F;
      4'd7:    g = 20'hF1111;
      4'd8:    g = 20'hF9F9F;
      4'd9:    g = 20'hF9F1F;
      default: g = 20'h00000;
    endcase
    fi = int'(fy);
    return g[(4 - fi) * 4 +: 4];
  endfunction

  // dx/dy are offsets from the field's top-left corner; each font pixel is 2x2 screen pixels.
  function automatic logic field_px(input logic [15:0] digits, input int dx, input int dy);
    int         pos;
    int         x;
    logic [3:0] d;
    logic [3:0] rbits;
    field_px = 1'b0;
    if (dx >= 0 && dx < 40 && dy >= 0 && dy < 10) begin
      pos = dx / 10;
      x   = dx % 10;
      if (x < 8) begin
        d        = digits[(3 - pos) * 4 +: 4];
        rbits    = font_row(d, 3'(dy / 2));
        field_px = rbits[3 - x / 2];
      end
    end
  endfunction

  assign tick      = fresh_q & ~fresh;
  assign score_inc = bcd_inc(score_q);

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    frame_cnt_d = frame_cnt_q;
    milestone_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!game_status) begin
          state_d = ST_OVER;
        end else if (tick) begin
          if (frame_cnt_q == FC_LAST) begin
            frame_cnt_d = '0;
            score_d     = score_inc;
            milestone_d = (score_inc[7:0] == 8'h00);
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        // IDLE and OVER behave alike: hold the score until the next game starts.
        if (game_status) begin
          state_d     = ST_RUN;
          score_d     = '0;
          frame_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      fresh_q     <= 1'b1;
      frame_cnt_q <= '0;
      score_q     <= '0;
      milestone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fresh_q     <= fresh;
      frame_cnt_q <= frame_cnt_d;
      score_q     <= score_d;
      milestone_q <= milestone_d;
    end
  end

`ifdef SCORE_HISCORE_EN
  logic [15:0] hiscore_d;

  // Raw 16-bit compare is order-preserving for packed BCD.
  always_comb begin
    hiscore_d = hiscore_q;
    if (state_q == ST_RUN && !game_status && score_q > hiscore_q) begin
      hiscore_d = score_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hiscore_q <= '0;
    end else begin
      hiscore_q <= hiscore_d;
    end
  end
`else
  assign hiscore_q = 16'h0000;
`endif

  always_comb begin
    col_i  = int'(col_addr);
    row_i  = int'(row_addr);
    px_lit = field_px(score_q, col_i - SCORE_COL, row_i - SCORE_ROW);
`ifdef SCORE_HISCORE_EN
    px_lit = px_lit | field_px(hiscore_q, col_i - (SCORE_COL - HI_GAP), row_i - SCORE_ROW);
`endif
  end

  assign score     = score_q;
  assign hiscore   = hiscore_q;
  assign milestone = milestone_q;
  assign px        = px_lit;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: the driver pushes per-cycle expectations from an
// integer-level game model, a separate monitor pops and compares them against the DUT.
module tb_score_keeper;

  localparam int FPP  = 2;
  localparam int SROW = 20;
  localparam int SCOL = 560;
  localparam int HGAP = 60;
`ifdef SCORE_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        fresh = 1'b1;
  logic        game_status = 1'b0;
  logic [8:0]  row_addr = '0;
  logic [9:0]  col_addr = '0;
  logic [15:0] score;
  logic [15:0] hiscore;
  logic        milestone;
  logic        px;

  always #5 CLK = ~CLK;

  score_keeper #(
    .FRAMES_PER_POINT(FPP),
    .SCORE_ROW(SROW),
    .SCORE_COL(SCOL),
    .HI_GAP(HGAP)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .fresh(fresh),
    .game_status(game_status),
    .row_addr(row_addr),
    .col_addr(col_addr),
    .score(score),
    .hiscore(hiscore),
    .milestone(milestone),
    .px(px)
  );

  typedef struct {
    logic [15:0] sc;
    logic [15:0] hi;
    logic        ms;
    logic        px;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;
  bit    done = 1'b0;

  // Game model kept as plain integers.
  int    m_sc = 0;
  int    m_hi = 0;
  int    m_frames = 0;
  bit    m_run = 1'b0;
  bit    m_prev_fresh = 1'b1;
  bit    m_ms = 1'b0;

  string font [10][5];
  int    sweep_row = -1;
  int    sweep_col = -1;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic bit field_lit(input int val, input int c0, input int row, input int col);
    int dx;
    int dy;
    int pos;
    int x;
    int dv;
    int dig;
    dx = col - c0;
    dy = row - SROW;
    if (dx < 0 || dx >= 40 || dy < 0 || dy >= 10) return 1'b0;
    pos = dx / 10;
    x   = dx % 10;
    if (x >= 8) return 1'b0;
    dv  = (pos == 0) ? 1000 : (pos == 1) ? 100 : (pos == 2) ? 10 : 1;
    dig = (val / dv) % 10;
    return font[dig][dy / 2].getc(x / 2) == "#";
  endfunction

  task automatic model_step(input bit rst, input bit fr, input bit gs);
    bit tk;
    tk   = m_prev_fresh && !fr;
    m_ms = 1'b0;
    if (rst) begin
      m_sc = 0;
      m_hi = 0;
      m_frames = 0;
      m_run = 1'b0;
      m_prev_fresh = 1'b1;
    end else begin
      if (!m_run) begin
        if (gs) begin
          m_run = 1'b1;
          m_sc = 0;
          m_frames = 0;
        end
      end else if (!gs) begin
        m_run = 1'b0;
        if (HI_EN && m_sc > m_hi) m_hi = m_sc;
      end else if (tk) begin
        m_frames++;
        if (m_frames == FPP) begin
          m_frames = 0;
          m_sc = (m_sc + 1) % 10000;
          m_ms = (m_sc % 100 == 0);
        end
      end
      m_prev_fresh = fr;
    end
  endtask

  task automatic cyc(input bit rst, input bit fr, input bit gs);
    exp_t e;
    int   r;
    int   c;
    @(posedge CLK);
    #2;
    r = (sweep_row >= 0) ? sweep_row : int'($urandom_range(SROW + 11, SROW - 2));
    c = (sweep_col >= 0) ? sweep_col : int'($urandom_range(SCOL + 44, SCOL - HGAP - 4));
    RESET       = rst;
    fresh       = fr;
    game_status = gs;
    row_addr    = 9'(r);
    col_addr    = 10'(c);
    model_step(rst, fr, gs);
    e.sc = to_bcd(m_sc);
    e.hi = to_bcd(m_hi);
    e.ms = m_ms;
    e.px = field_lit(m_sc, SCOL, r, c) | (HI_EN & field_lit(m_hi, SCOL - HGAP, r, c));
    sb.push_back(e);
  endtask

  task automatic tick(input bit gs);
    cyc(1'b0, 1'b1, gs);
    cyc(1'b0, 1'b0, gs);
  endtask

  task automatic chk16(input string nm, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, want, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    int   cycles;
    cycles = 0;
    while ((!done || sb.size() > 0) && cycles < 99000) begin
      @(posedge CLK);
      #1;
      cycles++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk16("score", score, e.sc);
        chk16("hiscore", hiscore, e.hi);
        chk1("milestone", milestone, e.ms);
        chk1("px", px, e.px);
      end
    end
    if (cycles >= 99000) begin
      checks++;
      failures++;
      $display("FAIL watchdog: ran %0d cycles, stimulus not finished", cycles);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : driver
    bit gs;
    font[0] = '{"####", "#..#", "#..#", "#..#", "####"};
    font[1] = '{"...#", "...#", "...#", "...#", "...#"};
    font[2] = '{"####", "...#", "####", "#...", "####"};
    font[3] = '{"####", "...#", "####", "...#", "####"};
    font[4] = '{"#..#", "#..#", "####", "...#", "...#"};
    font[5] = '{"####", "#...", "####", "...#", "####"};
    font[6] = '{"####", "#...", "####", "#..#", "####"};
    font[7] = '{"####", "...#", "...#", "...#", "...#"};
    font[8] = '{"####", "#..#", "####", "#..#", "####"};
    font[9] = '{"####", "#..#", "####", "...#", "####"};

    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0);

    // Start a game and count up to 0010, then on through 0100 and the 9999 wrap.
    cyc(1'b0, 1'b1, 1'b1);
    repeat (10 * FPP) tick(1'b1);
    while (m_sc != 99) tick(1'b1);
    repeat (FPP) tick(1'b1);
    while (m_sc != 9999) tick(1'b1);
    repeat (FPP) tick(1'b1);
    cyc(1'b0, 1'b1, 1'b0);

    // Games ending at 0123 then 0050.
    cyc(1'b0, 1'b1, 1'b1);
    while (m_sc != 123) tick(1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    while (m_sc != 50) tick(1'b1);
    cyc(1'b0, 1'b1, 1'b0);

    // Tick coincident with game end at score 0005, frame count one short of a point.
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    repeat (5 * FPP + FPP - 1) tick(1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // Tick coincident with game start, then fresh held low for several frames.
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    repeat (3 * FPP * 2) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);

    // Reset in the middle of a running game.
    repeat (4) tick(1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    repeat (3 * FPP) tick(1'b1);
    cyc(1'b0, 1'b1, 1'b0);

    // Glyph sweeps with score 0001.
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    repeat (FPP) tick(1'b1);
    sweep_row = SROW;
    for (int c = SCOL + 30; c <= SCOL + 39; c++) begin
      sweep_col = c;
      cyc(1'b0, 1'b1, 1'b1);
    end
    sweep_row = SROW + 10;
    for (int c = SCOL + 30; c <= SCOL + 39; c++) begin
      sweep_col = c;
      cyc(1'b0, 1'b1, 1'b1);
    end
    repeat (40 * FPP) tick(1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    for (int r = SROW; r <= SROW + 9; r++) begin
      sweep_row = r;
      for (int c = SCOL - HGAP; c <= SCOL + 39; c++) begin
        sweep_col = c;
        cyc(1'b0, 1'b1, 1'b0);
      end
    end
    sweep_row = -1;
    sweep_col = -1;

    // Random play.
    gs = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39, 0) == 0) gs = ~gs;
      cyc(($urandom_range(999, 0) == 0), 1'($urandom_range(1, 0)), gs);
    end
    cyc(1'b0, 1'b1, 1'b0);
    done = 1'b1;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Score and high-score stage fed by the game-status logic. While the game runs it counts frames, converts them into a 4-digit BCD score, and latches the best score when a game ends. It drives a score pixel stream (`px`) that the VGA stage ORs in beside `px_dinosaur`, `px_ground` and `px_cactus`. It also drives a milestone pulse for audio/flash effects.

## Interface
- `FRAMES_PER_POINT`, default 6: frame ticks per score increment (≥1).
- `SCORE_ROW`, default 20: top screen row of the digit field.
- `SCORE_COL`, default 560: left screen column of the score field.
- `HI_GAP`, default 60: the high-score field starts at `SCORE_COL - HI_GAP`.

Ports:
- `CLK` in 1: system clock.
- `RESET` in 1: synchronous, active-high reset.
- `fresh` in 1: VGA vertical sync. A 1→0 transition is one frame tick.
- `game_status` in 1: 1 = game running, 0 = stopped.
- `row_addr` in 9: current VGA row.
- `col_addr` in 10: current VGA column.
- `score` out 16: current score, 4 packed BCD digits, thousands in [15:12].
- `hiscore` out 16: best score, packed BCD.
- `milestone` out 1: one-cycle pulse when the score reaches a multiple of 100.
- `px` out 1: 1 when the current pixel lies on a lit score/high-score glyph pixel.

## Operation
- Frame tick: `fresh_d` is `fresh` registered on `CLK`. Tick = `fresh_d & ~fresh`. A held-low `fresh` yields exactly one tick.
- FSM states: IDLE, RUN, OVER.
  - IDLE → RUN on `game_status`=1: clear `score`, clear `frame_cnt`.
  - RUN → OVER on `game_status`=0: perform the high-score compare.
  - OVER → RUN on `game_status`=1: clear `score` and `frame_cnt`; `hiscore` is kept.
  - IDLE and OVER hold `score`.
- Counting, in RUN only, and only when `game_status`=1 and tick:
  - If `frame_cnt` = `FRAMES_PER_POINT`-1: `frame_cnt`←0 and `score` increments.
  - Otherwise: `frame_cnt`+1.
  - `frame_cnt` width is clog2(`FRAMES_PER_POINT`), minimum 1.
- BCD increment: the units digit increments. A 9 in any digit becomes 0 and carries into the next digit. 9999 wraps to 0000.
- `milestone` is asserted for one cycle on the edge where the new score has tens=0 and units=0. This includes the 0099→0100 step and the 9999→0000 wrap. It is never asserted for the clear on game start.
- High score: on the RUN→OVER edge, `hiscore`←`score` if `score` > `hiscore`. The comparison is unsigned on the raw 16-bit value (valid for BCD). Equal scores do not update.
- Rendering, combinational from `row_addr`/`col_addr` and the registered digits:
  - Glyph ROM: 4 columns × 5 rows per digit, 0–9, standard seven-segment-style shapes.
  - Each font pixel covers 2×2 screen pixels: cell 8 wide × 10 tall, digit pitch 10 columns.
  - Score field: columns `SCORE_COL`..`SCORE_COL`+39, rows `SCORE_ROW`..`SCORE_ROW`+9, thousands digit leftmost.
  - High-score field: same geometry at `SCORE_COL - HI_GAP`.
  - Columns 8–9 of each pitch are gaps; `px`=0 there.
- Reset values: `score`=0, `hiscore`=0, `milestone`=0, `frame_cnt`=0, state IDLE, `fresh_d`=1. `px` follows from these values.

## Timing
- `score` and `milestone` update on the same `CLK` edge that samples the tick. There is no further latency.
- `hiscore` updates on the edge that samples `game_status`=0 in RUN.
- `px` has zero latency relative to `row_addr`/`col_addr`, so it aligns with the other pixel sources.
- Simultaneous events:
  - Tick in the same cycle `game_status` falls: not counted; the compare uses the pre-tick score.
  - Tick in the same cycle `game_status` rises: the clear wins and the tick is not counted.
  - `RESET` overrides everything, including mid-RUN: the next state is IDLE and `hiscore`=0.

## Configuration
- `SCORE_HISCORE_EN` defined: high-score register, compare logic and high-score field rendering are present.
- `SCORE_HISCORE_EN` undefined: `hiscore` is tied to 16'h0000, no compare logic exists, and `px` covers only the score field.

## Test plan
- Assert `RESET` for 2 cycles → `score`=0000, `hiscore`=0000, `milestone`=0, `px`=0 everywhere.
- Raise `game_status`, then apply 60 frame ticks (`FRAMES_PER_POINT`=6) → `score`=0010, no `milestone` pulse.
- Run to 0099, then 6 more ticks → `score`=0100 and `milestone` high for exactly 1 cycle. Continue to 9999, then 6 more ticks → `score`=0000 with a `milestone` pulse.
- Game 1:
  - Stop at 0123 → `hiscore`=0123 on the falling-edge sample.
  - Restart → `score`=0000, `hiscore`=0123.
  - Stop at 0050 → `hiscore` stays 0123.
  - Build without `SCORE_HISCORE_EN` → `hiscore`=0000 always.
- Frame tick coincident with the `game_status` fall at `score`=0005, `frame_cnt`=5 → `score` stays 0005 and `hiscore`=0005. Hold `fresh` low for 3 frames' worth of cycles → exactly 1 tick counted.
- `score`=0001, `row_addr`=`SCORE_ROW`, `col_addr` sweeping `SCORE_COL`+30..+39 → `px` matches the top row of the "1" glyph scaled ×2. `px`=0 at `SCORE_COL`+38/39 and at `SCORE_ROW`+10.
